// File: rtl/rx_tx_pkg.sv
// Shared receive/transmit definitions: CRC-32 constants, per-byte reflected CRC
// helper and the FCS checker state encoding.
package rx_tx_pkg;

  localparam logic [31:0] CRC32_INIT              = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE_REFLECTED = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_POLY_REFLECTED    = 32'hEDB88320;

  typedef enum logic [1:0] {
    FCS_IDLE   = 2'd0,
    FCS_ACCUM  = 2'd1,
    FCS_RESULT = 2'd2
  } fcs_state_t;

  // Folds one byte into a reflected CRC-32, LSB of the byte first.
  function automatic logic [31:0] crc32_byte_refl(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY_REFLECTED;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_multibyte.sv
// Combinational fold of up to DATA_BYTES lanes into a reflected CRC-32;
// lane 0 is processed first, lanes with keep clear are skipped.
module crc32_multibyte
  import rx_tx_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic [31:0]             crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [31:0]             crc_out
);

  // Chain the per-byte update across the enabled lanes in wire order.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (keep[i]) begin
        crc_out = crc32_byte_refl(crc_out, data[8*i +: 8]);
      end else begin
        crc_out = crc_out;
      end
    end
  end

endmodule

// File: rtl/eth_fcs_checker.sv
// Ethernet frame FCS checker: accumulates CRC and length per frame and
// presents a held result (fcs_ok, runt, giant, frame_len) with a handshake.
module eth_fcs_checker
  import rx_tx_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int MIN_FRAME  = 64,
  parameter int MAX_FRAME  = 1518
) (
  input  logic                    clk,
  input  logic                    rst_n_in,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_sop,
  input  logic                    s_eop,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    fcs_ok,
  output logic                    runt,
  output logic                    giant,
  output logic [10:0]             frame_len
);

  localparam logic [11:0] LEN_SAT = 12'd2047;
  localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME);
  localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME);

  fcs_state_t            state_r, state_next_s;
  logic [31:0]           crc_r, crc_base_s, crc_fold_s;
  logic [10:0]           len_r, len_base_s, len_sum_sat_s;
  logic [11:0]           len_add_s, len_sum_s;
  logic [DATA_BYTES-1:0] keep_eff_s;
  logic                  beat_fire_s, fold_s;
  logic                  ready_r, res_valid_r, fcs_ok_r, runt_r, giant_r;
  logic [10:0]           frame_len_r;

  assign beat_fire_s = s_valid && ready_r;
  // A sop beat restarts accumulation whether we were idle or mid-frame.
  assign fold_s      = beat_fire_s && (s_sop || (state_r == FCS_ACCUM));
  assign crc_base_s  = s_sop ? CRC32_INIT : crc_r;
  assign len_base_s  = s_sop ? 11'd0 : len_r;
  assign keep_eff_s  = s_eop ? s_keep : {DATA_BYTES{1'b1}};

  crc32_multibyte #(.DATA_BYTES(DATA_BYTES)) u_crc (
    .crc_in  (crc_base_s),
    .data    (s_data),
    .keep    (keep_eff_s),
    .crc_out (crc_fold_s)
  );

  // Byte count contributed by this beat and saturating running length.
  always_comb begin
    len_add_s = 12'd0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (keep_eff_s[i]) begin
        len_add_s = len_add_s + 12'd1;
      end else begin
        len_add_s = len_add_s;
      end
    end
    len_sum_s = {1'b0, len_base_s} + len_add_s;
    if (len_sum_s > LEN_SAT) begin
      len_sum_sat_s = LEN_SAT[10:0];
    end else begin
      len_sum_sat_s = len_sum_s[10:0];
    end
  end

  // Frame FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FCS_IDLE, FCS_ACCUM: begin
        if (fold_s) begin
          state_next_s = s_eop ? FCS_RESULT : FCS_ACCUM;
        end else begin
          state_next_s = state_r;
        end
      end
      FCS_RESULT: begin
        if (res_ready) begin
          state_next_s = FCS_IDLE;
        end else begin
          state_next_s = FCS_RESULT;
        end
      end
      default: state_next_s = FCS_IDLE;
    endcase
  end

  // State, accumulators and registered result outputs.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= FCS_IDLE;
      crc_r       <= CRC32_INIT;
      len_r       <= 11'd0;
      ready_r     <= 1'b0;
      res_valid_r <= 1'b0;
      fcs_ok_r    <= 1'b0;
      runt_r      <= 1'b0;
      giant_r     <= 1'b0;
      frame_len_r <= 11'd0;
    end else begin
      state_r     <= state_next_s;
      ready_r     <= (state_next_s != FCS_RESULT);
      res_valid_r <= (state_next_s == FCS_RESULT);
      if (fold_s) begin
        crc_r <= crc_fold_s;
        len_r <= len_sum_sat_s;
      end
      if (fold_s && s_eop) begin
        fcs_ok_r    <= (crc_fold_s == CRC32_RESIDUE_REFLECTED);
        runt_r      <= ({1'b0, len_sum_sat_s} < MIN_LEN);
        giant_r     <= ({1'b0, len_sum_sat_s} > MAX_LEN);
        frame_len_r <= len_sum_sat_s;
      end
    end
  end

  assign s_ready   = ready_r;
  assign res_valid = res_valid_r;
  assign fcs_ok    = fcs_ok_r;
  assign runt      = runt_r;
  assign giant     = giant_r;
  assign frame_len = frame_len_r;

endmodule
